microwave_countdown_timer: RTL

//  BCD mm:ss countdown timer for the microwave controller; sits directly downstream of the

---
 rtl/microwave_pkg.sv | 15 +
 rtl/microwave_countdown_timer_digit.sv | 44 ++++
 rtl/microwave_countdown_timer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared types and constants for the microwave countdown timer
package microwave_pkg;

    localparam int DIGIT_W          = 4;
    localparam int BCD_MAX_ONES     = 9;
    localparam int BCD_MAX_SEC_TENS = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/microwave_countdown_timer_digit.sv
// rtl/microwave_countdown_timer_digit.sv - one BCD digit of the down counter with clamp-on-load and borrow chain
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load, ld_val  load ld_val (clamped to MAX) on the next clk
//   dec_en        decrement strobe for the whole counter
//   borrow_in     all lower digits are zero (tie high for the least significant digit)
//   digit         current digit value
//   borrow_out    borrow_in and this digit is zero
module bcd_digit_down
    import microwave_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = DIGIT_W'(BCD_MAX_ONES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] ld_val,
    input  logic               dec_en,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out
);

    logic [DIGIT_W-1:0] r_digit;
    logic [DIGIT_W-1:0] w_ld_clamped;

    assign w_ld_clamped = (ld_val > MAX) ? MAX : ld_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= w_ld_clamped;
        end else if (dec_en && borrow_in) begin
            // A digit only moves when every lower digit is wrapping through zero.
            r_digit <= (r_digit == '0) ? MAX : r_digit - DIGIT_W'(1);
        end
    end

    assign digit      = r_digit;
    assign borrow_out = borrow_in && (r_digit == '0);

endmodule

// File: rtl/microwave_countdown_timer.sv
// rtl/microwave_countdown_timer.sv - BCD mm:ss countdown timer with tick synchroniser, prescaler and run/pause/done FSM
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   tick_in                          slow divided clock, asynchronous to clk
//   load, ld_min_t..ld_sec_o         load cook time (IDLE or DONE only), digits clamped
//   start, stop, clear               run/resume, pause, abort (clear > stop > start > load)
//   min_t, min_o, sec_t, sec_o       current count, BCD
//   running                          high while counting
//   done                             one-clk pulse when the count reaches 00:00
//   zero                             count is 00:00
module microwave_countdown_timer
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_DEC = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_in,
    input  logic                load,
    input  logic [DIGIT_W-1:0]  ld_min_t,
    input  logic [DIGIT_W-1:0]  ld_min_o,
    input  logic [DIGIT_W-1:0]  ld_sec_t,
    input  logic [DIGIT_W-1:0]  ld_sec_o,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    output logic [DIGIT_W-1:0]  min_t,
    output logic [DIGIT_W-1:0]  min_o,
    output logic [DIGIT_W-1:0]  sec_t,
    output logic [DIGIT_W-1:0]  sec_o,
    output logic                running,
    output logic                done,
    output logic                zero
);

    localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_DEC - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_tick_prev;
    logic [7:0]               r_pre;
    logic                     r_running;
    logic                     r_done;
    logic                     r_zero;

    logic                     w_edge;
    logic                     w_dec;
    logic                     w_do_load;
    logic                     w_do_clear;
    logic                     w_dig_load;
    logic                     w_run_entry;
    logic                     w_cnt_zero;
    logic                     w_cnt_one;
    logic                     w_ld_zero;
    logic [DIGIT_W-1:0]       w_ld_min_t, w_ld_min_o, w_ld_sec_t, w_ld_sec_o;
    logic [DIGIT_W-1:0]       w_min_t, w_min_o, w_sec_t, w_sec_o;
    logic                     w_b_so, w_b_st, w_b_mo, w_b_mt;

    // Synchroniser and rising-edge detect for the slow tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= '0;
            r_tick_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], tick_in};
            r_tick_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = r_sync[SYNC_STAGES-1] && !r_tick_prev;

    // The borrow chain with borrow_in tied high doubles as the 00:00 detector.
    assign w_cnt_zero = w_b_mt;
    assign w_cnt_one  = (w_min_t == '0) && (w_min_o == '0) && (w_sec_t == '0)
                        && (w_sec_o == DIGIT_W'(1));

    assign w_dec = (r_state == ST_RUN) && !clear && w_edge
                   && (r_pre == PRE_LAST) && !w_cnt_zero;

    always_comb begin
        w_next     = r_state;
        w_do_load  = 1'b0;
        w_do_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear) begin
                    w_do_clear = 1'b1;
                end else if (start && !w_cnt_zero) begin
                    w_next = ST_RUN;
                end else if (load) begin
                    w_do_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    w_next     = ST_IDLE;
                    w_do_clear = 1'b1;
                end else if (w_dec && w_cnt_one) begin
                    // Reaching 00:00 outranks a simultaneous stop.
                    w_next = ST_DONE;
                end else if (stop) begin
                    w_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    w_next     = ST_IDLE;
                    w_do_clear = 1'b1;
                end else if (!stop && start) begin
                    w_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (clear) begin
                    w_next     = ST_IDLE;
                    w_do_clear = 1'b1;
                end else if (load) begin
                    w_next    = ST_IDLE;
                    w_do_load = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_run_entry = (w_next == ST_RUN) && (r_state != ST_RUN);
    assign w_dig_load  = w_do_load || w_do_clear;

    // Clear reuses the digit load path with an all-zero value.
    assign w_ld_min_t = w_do_clear ? '0 : ld_min_t;
    assign w_ld_min_o = w_do_clear ? '0 : ld_min_o;
    assign w_ld_sec_t = w_do_clear ? '0 : ld_sec_t;
    assign w_ld_sec_o = w_do_clear ? '0 : ld_sec_o;
    assign w_ld_zero  = (w_ld_min_t == '0) && (w_ld_min_o == '0)
                        && (w_ld_sec_t == '0) && (w_ld_sec_o == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pre     <= 8'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_zero    <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_running <= (w_next == ST_RUN);
            r_done    <= (r_state == ST_RUN) && (w_next == ST_DONE);
            // zero is predicted from the next count so it lines up with the digits.
            if (w_dig_load) begin
                r_zero <= w_ld_zero;
            end else if (w_dec) begin
                r_zero <= w_cnt_one;
            end
            if (w_dig_load || w_run_entry) begin
                r_pre <= 8'd0;
            end else if ((r_state == ST_RUN) && w_edge) begin
                r_pre <= (r_pre == PRE_LAST) ? 8'd0 : r_pre + 8'd1;
            end
        end
    end

    bcd_digit_down #(.MAX(DIGIT_W'(BCD_MAX_ONES))) u_sec_o (
        .clk(clk), .rst(rst), .load(w_dig_load), .ld_val(w_ld_sec_o),
        .dec_en(w_dec), .borrow_in(1'b1), .digit(w_sec_o), .borrow_out(w_b_so)
    );

    bcd_digit_down #(.MAX(DIGIT_W'(BCD_MAX_SEC_TENS))) u_sec_t (
        .clk(clk), .rst(rst), .load(w_dig_load), .ld_val(w_ld_sec_t),
        .dec_en(w_dec), .borrow_in(w_b_so), .digit(w_sec_t), .borrow_out(w_b_st)
    );

    bcd_digit_down #(.MAX(DIGIT_W'(BCD_MAX_ONES))) u_min_o (
        .clk(clk), .rst(rst), .load(w_dig_load), .ld_val(w_ld_min_o),
        .dec_en(w_dec), .borrow_in(w_b_st), .digit(w_min_o), .borrow_out(w_b_mo)
    );

    // min_t never sees a borrow at 0 because decrement is blocked at 00:00.
    bcd_digit_down #(.MAX(DIGIT_W'(BCD_MAX_ONES))) u_min_t (
        .clk(clk), .rst(rst), .load(w_dig_load), .ld_val(w_ld_min_t),
        .dec_en(w_dec), .borrow_in(w_b_mo), .digit(w_min_t), .borrow_out(w_b_mt)
    );

    assign min_t   = w_min_t;
    assign min_o   = w_min_o;
    assign sec_t   = w_sec_t;
    assign sec_o   = w_sec_o;
    assign running = r_running;
    assign done    = r_done;
    assign zero    = r_zero;

endmodule
